// File: rtl/abs_arb_pkg.sv
// Shared types and helpers for the round-robin absolute-value arbiter.
// Optional saturation flag port is enabled with ABS_ARB_SAT_FLAG_EN.
package abs_arb_pkg;

  localparam int ABS_ARB_MAX_REQ = 16;
  localparam int ABS_ARB_MAX_W   = 64;

  typedef struct packed {
    logic [ABS_ARB_MAX_W-1:0] data;
    logic [3:0]               id;
    logic                     sat;
  } abs_rsp_t;

  // Returns {sat, |x|} for a W-bit signed operand sign-extended into x.
  function automatic logic [ABS_ARB_MAX_W:0] abs_sat(input logic signed [ABS_ARB_MAX_W-1:0] x,
                                                      input int w);
    logic signed [ABS_ARB_MAX_W-1:0] v_min;
    logic        [ABS_ARB_MAX_W-1:0] v_max;
    v_min = -(64'sd1 <<< (w - 1));
    v_max = (64'd1 << (w - 1)) - 64'd1;
    if (x == v_min)
      abs_sat = {1'b1, v_max};
    else if (x < 0)
      abs_sat = {1'b0, 64'(-x)};
    else
      abs_sat = {1'b0, 64'(x)};
  endfunction

endpackage

// File: rtl/abs_sat_unit.sv
// Combinational saturating two's-complement absolute value.
// The sat output exists only when ABS_ARB_SAT_FLAG_EN is defined.
module abs_sat_unit #(
  parameter int pDATA_WIDTH = 32
) (
  input  logic [pDATA_WIDTH-1:0] i_x,
`ifdef ABS_ARB_SAT_FLAG_EN
  output logic                   o_sat,
`endif
  output logic [pDATA_WIDTH-1:0] o_abs
);

  localparam logic [pDATA_WIDTH-1:0] lpMIN = {1'b1, {(pDATA_WIDTH-1){1'b0}}};

  logic signed [pDATA_WIDTH-1:0] w_x;
  logic                          w_is_min;

  assign w_x      = i_x;
  assign w_is_min = (i_x == lpMIN);

  // The most negative value has no positive counterpart; clamp to the max.
  always_comb begin
    if (w_is_min)
      o_abs = ~lpMIN;
    else if (w_x < 0)
      o_abs = ~i_x + 1'b1;
    else
      o_abs = i_x;
  end

`ifdef ABS_ARB_SAT_FLAG_EN
  assign o_sat = w_is_min;
`endif

endmodule

// File: rtl/abs_share_arb.sv
// Round-robin arbiter sharing one saturating abs datapath among requesters.
// Define ABS_ARB_SAT_FLAG_EN to add the rsp_sat port and its register.
module abs_share_arb
  import abs_arb_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pNUM_REQ    = 4,
  parameter int pID_WIDTH   = $clog2(pNUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [pNUM_REQ-1:0]             req_valid,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0] req_data,
  output logic [pNUM_REQ-1:0]             req_ready,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [pDATA_WIDTH-1:0]          rsp_data,
`ifdef ABS_ARB_SAT_FLAG_EN
  output logic                            rsp_sat,
`endif
  output logic [pID_WIDTH-1:0]            rsp_id
);

  logic                   w_can_accept;
  logic                   w_gnt_found;
  logic [pID_WIDTH-1:0]   w_gnt_id;
  logic [pID_WIDTH:0]     w_scan;
  logic [pNUM_REQ-1:0]    w_ready;
  logic                   w_hs;
  logic [pDATA_WIDTH-1:0] w_opnd;
  logic [pDATA_WIDTH-1:0] w_abs;

  logic [pID_WIDTH-1:0]   r_rr_ptr;
  logic                   r_rsp_valid;
  logic [pDATA_WIDTH-1:0] r_rsp_data;
  logic [pID_WIDTH-1:0]   r_rsp_id;

  assign w_can_accept = !r_rsp_valid || rsp_ready;

  // Scan upward from the pointer, wrapping at pNUM_REQ (not at a power of two).
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_scan      = '0;
    for (int k = 0; k < pNUM_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (pID_WIDTH+1)'(k);
      if (w_scan >= (pID_WIDTH+1)'(pNUM_REQ))
        w_scan = w_scan - (pID_WIDTH+1)'(pNUM_REQ);
      if (!w_gnt_found && req_valid[w_scan[pID_WIDTH-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_scan[pID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_gnt_found && w_can_accept && !rst)
      w_ready[w_gnt_id] = 1'b1;
  end

  assign w_hs      = |w_ready;
  assign req_ready = w_ready;
  assign w_opnd    = req_data[w_gnt_id*pDATA_WIDTH +: pDATA_WIDTH];

`ifdef ABS_ARB_SAT_FLAG_EN
  logic w_sat;
  logic r_rsp_sat;

  abs_sat_unit #(.pDATA_WIDTH(pDATA_WIDTH)) u_abs (
    .i_x   (w_opnd),
    .o_sat (w_sat),
    .o_abs (w_abs)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_rsp_sat <= 1'b0;
    else if (w_hs)
      r_rsp_sat <= w_sat;
  end

  assign rsp_sat = r_rsp_sat;
`else
  abs_sat_unit #(.pDATA_WIDTH(pDATA_WIDTH)) u_abs (
    .i_x   (w_opnd),
    .o_abs (w_abs)
  );
`endif

  // Output register stage: load on handshake, clear on a lone transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_hs) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_abs;
      r_rsp_id    <= w_gnt_id;
      r_rr_ptr    <= (w_gnt_id == pID_WIDTH'(pNUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_abs_share_arb.sv
// Bench for abs_share_arb (W=8, N=4): directed vector table plus random traffic
// against a behavioural model; rsp_sat is checked when ABS_ARB_SAT_FLAG_EN is set.
module tb_abs_share_arb;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_id;
`ifdef ABS_ARB_SAT_FLAG_EN
  logic         rsp_sat;
`endif

  always #5 clk = ~clk;

  abs_share_arb #(.pDATA_WIDTH(W), .pNUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef ABS_ARB_SAT_FLAG_EN
    .rsp_sat   (rsp_sat),
`endif
    .rsp_id    (rsp_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  vld;
    logic [31:0] data;
    bit          rr;
    logic [3:0]  e_ready;
    bit          e_vld;
    bit          chk;
    logic [7:0]  e_data;
    logic [1:0]  e_id;
    bit          e_sat;
  } vec_t;

  // Behavioural reference state
  int m_ptr;
  bit m_pv;
  int m_pdata;
  int m_pid;
  bit m_psat;

  task automatic ref_abs(input logic [7:0] d, output int a, output bit s);
    int v;
    v = $signed(d);
    s = (v == -128);
    if (v == -128) a = 127;
    else if (v < 0) a = -v;
    else a = v;
  endtask

  function automatic int model_grant(input logic [3:0] vld);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  localparam logic [31:0] D_RR = 32'hFC03FE01;  // {-4, 3, -2, 1}

  vec_t tv[22];

  initial begin
    logic [3:0]  rv;
    logic [31:0] rd;

    tv[0]  = '{1, 4'h0, 32'h0,        1, 4'h0, 0, 1, 8'd0,   2'd0, 0};
    tv[1]  = '{0, 4'h0, 32'h0,        1, 4'h0, 0, 1, 8'd0,   2'd0, 0};
    tv[2]  = '{0, 4'h4, 32'h00FB0000, 1, 4'h4, 0, 0, 8'd0,   2'd0, 0};
    tv[3]  = '{0, 4'h0, 32'h00FB0000, 1, 4'h0, 1, 1, 8'd5,   2'd2, 0};
    tv[4]  = '{0, 4'h1, 32'h00000080, 1, 4'h1, 0, 0, 8'd0,   2'd0, 0};
    tv[5]  = '{0, 4'h1, 32'h0000007F, 1, 4'h1, 1, 1, 8'd127, 2'd0, 1};
    tv[6]  = '{0, 4'h1, 32'h00000000, 1, 4'h1, 1, 1, 8'd127, 2'd0, 0};
    tv[7]  = '{0, 4'h0, 32'h00000000, 1, 4'h0, 1, 1, 8'd0,   2'd0, 0};
    tv[8]  = '{1, 4'h0, 32'h00000000, 1, 4'h0, 0, 1, 8'd0,   2'd0, 0};
    tv[9]  = '{0, 4'hF, D_RR,         1, 4'h1, 0, 0, 8'd0,   2'd0, 0};
    tv[10] = '{0, 4'hF, D_RR,         1, 4'h2, 1, 1, 8'd1,   2'd0, 0};
    tv[11] = '{0, 4'hF, D_RR,         1, 4'h4, 1, 1, 8'd2,   2'd1, 0};
    tv[12] = '{0, 4'hF, D_RR,         1, 4'h8, 1, 1, 8'd3,   2'd2, 0};
    tv[13] = '{0, 4'hF, D_RR,         1, 4'h1, 1, 1, 8'd4,   2'd3, 0};
    tv[14] = '{0, 4'hF, D_RR,         0, 4'h0, 1, 1, 8'd1,   2'd0, 0};
    tv[15] = '{0, 4'hF, D_RR,         0, 4'h0, 1, 1, 8'd1,   2'd0, 0};
    tv[16] = '{0, 4'hF, D_RR,         0, 4'h0, 1, 1, 8'd1,   2'd0, 0};
    tv[17] = '{0, 4'hF, D_RR,         1, 4'h2, 1, 1, 8'd1,   2'd0, 0};
    tv[18] = '{0, 4'hF, D_RR,         0, 4'h0, 1, 1, 8'd2,   2'd1, 0};
    tv[19] = '{1, 4'hF, D_RR,         0, 4'h0, 1, 1, 8'd2,   2'd1, 0};
    tv[20] = '{0, 4'hF, D_RR,         0, 4'h1, 0, 1, 8'd0,   2'd0, 0};
    tv[21] = '{0, 4'h0, D_RR,         1, 4'h0, 1, 1, 8'd1,   2'd0, 0};

    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Directed sequence: each entry's expectations are sampled before its edge
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = tv[i].rst; req_valid = tv[i].vld; req_data = tv[i].data; rsp_ready = tv[i].rr;
      #1;
      check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tv[i].e_ready));
      check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].e_vld));
      if (tv[i].chk) begin
        check($sformatf("vec%0d rsp_data", i), 32'(rsp_data), 32'(tv[i].e_data));
        check($sformatf("vec%0d rsp_id", i), 32'(rsp_id), 32'(tv[i].e_id));
`ifdef ABS_ARB_SAT_FLAG_EN
        check($sformatf("vec%0d rsp_sat", i), 32'(rsp_sat), 32'(tv[i].e_sat));
`endif
      end
    end

    // Random traffic against the reference model
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    m_ptr = 0; m_pv = 1'b0; m_pdata = 0; m_pid = 0; m_psat = 1'b0;
    rv = '0; rd = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int          g;
      logic [3:0]  e_ready;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) != 0) begin
          rv[i] = 1'b1;
          case ($urandom_range(0, 5))
            0:       rd[i*8 +: 8] = 8'h80;
            1:       rd[i*8 +: 8] = 8'h7F;
            2:       rd[i*8 +: 8] = 8'h00;
            3:       rd[i*8 +: 8] = 8'hFF;
            default: rd[i*8 +: 8] = 8'($urandom);
          endcase
        end
      end
      rst       = ($urandom_range(0, 99) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = rv;
      req_data  = rd;
      #1;

      g = model_grant(rv);
      e_ready = '0;
      if (!rst && !(m_pv && !rsp_ready) && g >= 0) e_ready[g] = 1'b1;

      check("rnd req_ready", 32'(req_ready), 32'(e_ready));
      check("rnd rsp_valid", 32'(rsp_valid), 32'(m_pv));
      if (m_pv) begin
        check("rnd rsp_data", 32'(rsp_data), 32'(m_pdata));
        check("rnd rsp_id", 32'(rsp_id), 32'(m_pid));
`ifdef ABS_ARB_SAT_FLAG_EN
        check("rnd rsp_sat", 32'(rsp_sat), 32'(m_psat));
`endif
      end

      if (rst) begin
        m_ptr = 0; m_pv = 1'b0; m_pdata = 0; m_pid = 0; m_psat = 1'b0;
      end else if (e_ready != 0) begin
        ref_abs(rd[g*8 +: 8], m_pdata, m_psat);
        m_pid = g;
        m_pv  = 1'b1;
        m_ptr = (g + 1) % N;
        rv[g] = 1'b0;
      end else if (rsp_ready) begin
        m_pv = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
